// File: rtl/tx_unit.sv
// Serial 8N1 transmit unit on the sequencer output-register bus.
// Bytes are queued in a small FIFO and shifted out LSB first at a programmable bit period.
module tx_unit #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] inst,
  input  logic        inst_en,
  output logic        tx,
  output logic        ready,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [15:0]     div_q, div_d;
  logic [15:0]     fd_q, fd_d;
  logic [15:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [2:0]      idx_q, idx_d;
  logic            tx_q, tx_d;
  logic            ovf_q, ovf_d;
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic [3:0] op;
  logic [7:0] imm;
  logic       is_ldl, is_ldh, is_send, is_clr;
  logic       nonempty, full, bit_done, pop, push;
  logic [2:0] idx_next;

  assign op       = inst[11:8];
  assign imm      = inst[7:0];
  assign is_ldl   = inst_en && (op == 4'd1);
  assign is_ldh   = inst_en && (op == 4'd2);
  assign is_send  = inst_en && (op == 4'd3);
  assign is_clr   = inst_en && (op == 4'd4);
  assign nonempty = (count_q != '0);
  assign full     = (count_q == DepthC);
  assign bit_done = (bit_cnt_q == fd_q);
  assign idx_next = idx_q + 3'd1;

  // Frame sequencer; the frame divisor is latched at pop so DIV writes only affect later frames.
  always_comb begin
    state_d   = state_q;
    fd_d      = fd_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (nonempty) begin
          pop       = 1'b1;
          state_d   = StStart;
          tx_d      = 1'b0;
          fd_d      = div_q;
          shreg_d   = mem_q[rptr_q];
          bit_cnt_d = '0;
        end
      end
      StStart: begin
        if (bit_done) begin
          state_d   = StData;
          idx_d     = 3'd0;
          bit_cnt_d = '0;
          tx_d      = shreg_q[0];
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
      StData: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_next;
            tx_d  = shreg_q[idx_next];
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
      StStop: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          if (nonempty) begin
            pop     = 1'b1;
            state_d = StStart;
            tx_d    = 1'b0;
            fd_d    = div_q;
            shreg_d = mem_q[rptr_q];
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    // CLR wins over any pop in the same cycle.
    if (is_clr) begin
      state_d   = StIdle;
      tx_d      = 1'b1;
      bit_cnt_d = '0;
      pop       = 1'b0;
    end
  end

  // A full FIFO still takes a byte when the sequencer pops in the same cycle.
  assign push = is_send && (!full || pop);

  always_comb begin
    div_d   = div_q;
    ovf_d   = ovf_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (is_ldl) div_d[7:0]  = imm;
    if (is_ldh) div_d[15:8] = imm;
    if (push) wptr_d = wptr_q + PtrW'(1);
    if (pop)  rptr_d = rptr_q + PtrW'(1);
    if (push && !pop)      count_d = count_q + CntW'(1);
    else if (pop && !push) count_d = count_q - CntW'(1);
    if (is_send && !push) ovf_d = 1'b1;
    if (is_clr) begin
      ovf_d   = 1'b0;
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= StIdle;
      div_q     <= DIV_RESET;
      fd_q      <= DIV_RESET;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      idx_q     <= '0;
      tx_q      <= 1'b1;
      ovf_q     <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      fd_q      <= fd_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      idx_q     <= idx_d;
      tx_q      <= tx_d;
      ovf_q     <= ovf_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= imm;
  end

  assign tx       = tx_q;
  assign overflow = ovf_q;
  assign ready    = !full;
  assign busy     = nonempty || (state_q != StIdle);

endmodule

// File: tb/tb_tx_unit.sv
// Directed bench for tx_unit: a per-cycle vector table for the FIFO/overflow path
// plus hand-written sequences for frame timing, CLR, divisor latching and reset.
module tb_tx_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] inst;
  logic        inst_en;
  logic        tx, ready, busy, overflow;

  int n_checks = 0;
  int n_pass   = 0;

  tx_unit #(.FIFO_DEPTH(4), .DIV_RESET(16'd433)) dut (
    .clock    (clock),
    .reset    (reset),
    .inst     (inst),
    .inst_en  (inst_en),
    .tx       (tx),
    .ready    (ready),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  localparam logic [3:0] NOP = 4'd0, LDL = 4'd1, LDH = 4'd2, SEND = 4'd3, CLR = 4'd4;

  typedef struct {
    logic [3:0] op;
    logic [7:0] imm;
    logic       en;
    logic [3:0] exp;  // {tx, ready, busy, overflow} after the edge
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] op, input logic [7:0] imm, input logic en,
                              input logic [3:0] exp);
    vec_t v;
    v.op  = op;
    v.imm = imm;
    v.en  = en;
    v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] imm);
    inst    = {op, imm};
    inst_en = 1'b1;
    tick();
    inst_en = 1'b0;
    inst    = '0;
  endtask

  // Called just after the edge at offset 'skip' within a frame that began with its start bit.
  task automatic expect_frame(input logic [7:0] b, input int per, input int skip,
                              input string name);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = skip; i < 10 * per; i++) begin
      check($sformatf("%s cyc%0d", name, i), 32'(tx), 32'(f[i / per]));
      tick();
    end
  endtask

  task automatic wait_idle(input int bound, input string name);
    int n;
    n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  initial begin
    int lows;
    reset   = 1'b0;
    inst    = '0;
    inst_en = 1'b0;

    // Reset state
    idle(3);
    check("reset state", 32'({tx, ready, busy, overflow}), 32'b1100);
    reset = 1'b1;

    // 0xA5 at two cycles per bit
    issue(LDL, 8'h01);
    issue(LDH, 8'h00);
    issue(SEND, 8'hA5);
    check("t2 queued", 32'({tx, busy}), 32'b11);
    tick();
    expect_frame(8'hA5, 2, 0, "t2 frame");
    check("t2 done", 32'({tx, busy}), 32'b10);

    // Per-cycle table: ignored instructions, then DIV=0 burst into a 4-deep FIFO
    vecs.push_back(mk(NOP,   8'h00, 1'b1, 4'b1100));
    vecs.push_back(mk(4'd7,  8'hFF, 1'b1, 4'b1100));
    vecs.push_back(mk(SEND,  8'h55, 1'b0, 4'b1100));
    vecs.push_back(mk(LDL,   8'h00, 1'b1, 4'b1100));
    vecs.push_back(mk(SEND,  8'h01, 1'b1, 4'b1110));
    vecs.push_back(mk(SEND,  8'h02, 1'b1, 4'b0110));
    vecs.push_back(mk(SEND,  8'h03, 1'b1, 4'b1110));
    vecs.push_back(mk(SEND,  8'h04, 1'b1, 4'b0110));
    vecs.push_back(mk(SEND,  8'h05, 1'b1, 4'b0010));
    vecs.push_back(mk(SEND,  8'h06, 1'b1, 4'b0011));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(NOP, 8'h00, 1'b0, 4'b0011));
    vecs.push_back(mk(NOP,   8'h00, 1'b0, 4'b1011));
    vecs.push_back(mk(NOP,   8'h00, 1'b0, 4'b0111));
    vecs.push_back(mk(NOP,   8'h00, 1'b0, 4'b0111));
    vecs.push_back(mk(NOP,   8'h00, 1'b0, 4'b1111));
    for (int i = 0; i < 6; i++) vecs.push_back(mk(NOP, 8'h00, 1'b0, 4'b0111));
    vecs.push_back(mk(NOP,   8'h00, 1'b0, 4'b1111));
    vecs.push_back(mk(NOP,   8'h00, 1'b0, 4'b0111));
    foreach (vecs[i]) begin
      inst    = {vecs[i].op, vecs[i].imm};
      inst_en = vecs[i].en;
      tick();
      inst_en = 1'b0;
      inst    = '0;
      check($sformatf("vec%0d {tx,ready,busy,ovf}", i), 32'({tx, ready, busy, overflow}),
            32'(vecs[i].exp));
    end
    wait_idle(100, "t3 drain");
    check("t3 overflow sticky", 32'(overflow), 32'd1);

    // CLR during data bit 3 with two bytes queued
    issue(LDL, 8'h01);
    issue(SEND, 8'h08);
    issue(SEND, 8'h22);
    issue(SEND, 8'h33);
    idle(7);
    check("t4 in bit3", 32'(tx), 32'd1);
    issue(CLR, 8'h00);
    check("t4 after clr", 32'({tx, ready, busy, overflow}), 32'b1100);
    lows = 0;
    repeat (40) begin
      tick();
      if (!tx) lows++;
    end
    check("t4 no start bits", 32'(lows), 32'd0);

    // DIV change mid-frame only affects the next frame
    issue(LDL, 8'h03);
    issue(SEND, 8'h00);
    issue(SEND, 8'hFF);
    check("t5 start", 32'(tx), 32'd0);
    issue(LDL, 8'h00);
    expect_frame(8'h00, 4, 1, "t5 frame1");
    expect_frame(8'hFF, 1, 0, "t5 frame2");
    check("t5 done", 32'({tx, busy}), 32'b10);

    // Push into a full FIFO on the same edge as a pop
    issue(SEND, 8'hA1);
    issue(SEND, 8'hA2);
    issue(SEND, 8'hA3);
    issue(SEND, 8'hA4);
    issue(SEND, 8'hA5);
    check("t5 full", 32'({ready, overflow}), 32'b00);
    idle(6);
    issue(SEND, 8'hA6);
    check("t5 push+pop", 32'({tx, ready, overflow}), 32'b000);
    issue(CLR, 8'h00);
    check("t5 clr", 32'({tx, ready, busy, overflow}), 32'b1100);

    // Reset mid-frame
    issue(LDL, 8'h05);
    issue(SEND, 8'h00);
    issue(SEND, 8'h00);
    idle(10);
    check("t6 mid-frame", 32'({tx, busy}), 32'b01);
    reset = 1'b0;
    tick();
    check("t6 reset", 32'({tx, ready, busy, overflow}), 32'b1100);
    reset = 1'b1;
    idle(5);
    check("t6 no residue", 32'({tx, busy}), 32'b10);
    issue(SEND, 8'hFF);
    tick();
    check("t6 start", 32'(tx), 32'd0);
    idle(433);
    check("t6 start end", 32'(tx), 32'd0);
    tick();
    check("t6 bit0", 32'(tx), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
